// File: rtl/sw_result_collector.sv
// Collects per-query best score/index from the Smith-Waterman result stream into a record FIFO.
// Build option: define SW_COLLECT_THRESH_EN to add thresh_i, which suppresses records whose best < thresh_i.
module sw_result_collector #(
  parameter int CALC_BIT   = 10,
  parameter int IDX_BIT    = 8,
  parameter int QID_BIT    = 8,
  parameter int CNT_BIT    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [CALC_BIT-1:0] result_i,
  input  logic                valid_i,
  input  logic [CALC_BIT-1:0] max_result_i,
  input  logic [IDX_BIT-1:0]  match_idx_i,
  input  logic                change_q_i,
`ifdef SW_COLLECT_THRESH_EN
  input  logic [CALC_BIT-1:0] thresh_i,
`endif
  output logic                rec_valid_o,
  input  logic                rec_ready_i,
  output logic [QID_BIT-1:0]  rec_qid_o,
  output logic [CALC_BIT-1:0] rec_score_o,
  output logic [IDX_BIT-1:0]  rec_idx_o,
  output logic [CNT_BIT-1:0]  rec_cnt_o,
  output logic                rec_chk_err_o,
  output logic                overflow_o,
  output logic [7:0]          drop_cnt_o,
  output logic                busy_o
);

  localparam int PTR_BIT  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FILL_BIT = PTR_BIT + 1;
  localparam logic [FILL_BIT-1:0] FULL_LVL = FILL_BIT'(FIFO_DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic [QID_BIT-1:0]  qid;
    logic [CALC_BIT-1:0] score;
    logic [IDX_BIT-1:0]  idx;
    logic [CNT_BIT-1:0]  cnt;
    logic                chk_err;
  } rec_t;

  state_t              state_q, state_d;
  logic [CALC_BIT-1:0] best_q, best_d;
  logic [IDX_BIT-1:0]  idx_q, idx_d;
  logic [CNT_BIT-1:0]  cnt_q, cnt_d;
  logic [QID_BIT-1:0]  qid_q, qid_d;
  logic [4:0]          quiet_q, quiet_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_q, drop_d;
  rec_t                mem_q [FIFO_DEPTH];
  rec_t                mem_d [FIFO_DEPTH];
  logic [PTR_BIT-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FILL_BIT-1:0] fill_q, fill_d;

  logic                beat, close, take, keep, push, pop, drop, full;
  logic [CALC_BIT-1:0] fold_best;
  logic [IDX_BIT-1:0]  fold_idx;
  logic [CNT_BIT-1:0]  fold_cnt;
  rec_t                new_rec, head;

  // A beat in the closing cycle is folded in before the record is formed.
  always_comb begin
    beat      = (state_q == ACCUM) && !start_i && valid_i;
    close     = (state_q == ACCUM) && !start_i && change_q_i;
    take      = beat && ((cnt_q == '0) || (result_i > best_q));
    fold_best = take ? result_i : best_q;
    fold_idx  = take ? match_idx_i : idx_q;
    fold_cnt  = (beat && (cnt_q != '1)) ? cnt_q + CNT_BIT'(1) : cnt_q;
`ifdef SW_COLLECT_THRESH_EN
    keep      = (fold_cnt != '0) && (fold_best >= thresh_i);
`else
    keep      = (fold_cnt != '0);
`endif
    new_rec   = '{qid: qid_q, score: fold_best, idx: fold_idx, cnt: fold_cnt,
                  chk_err: (max_result_i != fold_best)};
    full      = (fill_q == FULL_LVL);
    pop       = rec_valid_o && rec_ready_i;
    push      = close && keep && (!full || pop);
    drop      = close && keep && full && !pop;
  end

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q + FILL_BIT'(push) - FILL_BIT'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = new_rec;
      wr_ptr_d        = wr_ptr_q + PTR_BIT'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_BIT'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    best_d     = best_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    qid_d      = qid_q;
    quiet_d    = quiet_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (start_i) begin
      state_d    = ACCUM;
      best_d     = '0;
      idx_d      = '0;
      cnt_d      = '0;
      qid_d      = '0;
      quiet_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else if (state_q == ACCUM) begin
      if (close) begin
        best_d = '0;
        idx_d  = '0;
        cnt_d  = '0;
        qid_d  = qid_q + QID_BIT'(1);
      end else begin
        best_d = fold_best;
        idx_d  = fold_idx;
        cnt_d  = fold_cnt;
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
      // quiet_q counts earlier idle cycles; this cycle being idle makes the 16th.
      if (valid_i || change_q_i) begin
        quiet_d = '0;
      end else begin
        if (quiet_q != 5'd16) quiet_d = quiet_q + 5'd1;
        if ((quiet_q >= 5'd15) && (fill_q == '0)) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      best_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      qid_q      <= '0;
      quiet_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      best_q     <= best_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      qid_q      <= qid_d;
      quiet_q    <= quiet_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      mem_q      <= mem_d;
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign rec_valid_o   = (fill_q != '0);
  assign rec_qid_o     = head.qid;
  assign rec_score_o   = head.score;
  assign rec_idx_o     = head.idx;
  assign rec_cnt_o     = head.cnt;
  assign rec_chk_err_o = head.chk_err;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_q;
  assign busy_o        = (state_q == ACCUM) || (fill_q != '0);

endmodule
